reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 8 x 8-bit general-purpose register file for the single-cycle processor.
- Sits directly upstream of the ALU:
  - OUT1 drives ALU operand 1.
  - OUT2 drives operand 2, via the negate/immediate muxes, into the FORWARD/ADD/AND/OR units.
  - ALU result returns on IN for write-back.
- Two combinational read ports and one clocked write port, plus per-register written-since-reset flags for verification and hazard debug.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, register address width; depth = 2**ADDR_W = 8.
- BYPASS, 0, 1 = write-through: a read of the address being written returns IN in the same cycle.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RESET  input  1  asynchronous, active-low reset.
- IN  input  DATA_W  write-back data (ALU result or memory load data).
- INADDRESS  input  ADDR_W  destination register.
- WRITE  input  1  write enable from control unit.
- BUSYWAIT  input  1  memory stall; blocks register writes while high.
- OUT1ADDRESS  input  ADDR_W  read port 1 address.
- OUT2ADDRESS  input  ADDR_W  read port 2 address.
- OUT1  output  DATA_W  read port 1 data (to ALU DATA1).
- OUT2  output  DATA_W  read port 2 data (toward ALU DATA2).
- OUT1_VALID  output  1  register at OUT1ADDRESS written since last reset.
- OUT2_VALID  output  1  register at OUT2ADDRESS written since last reset.

Behaviour:
- Storage: regs[0..7], each DATA_W bits; valid[0..7], each 1 bit. Register 0 is an ordinary register, not hardwired to zero.
- Reset:
  - RESET low clears all regs to 0 and all valid bits to 0 immediately, with no clock needed.
  - While RESET is low: OUT1 = OUT2 = 0, OUT1_VALID = OUT2_VALID = 0, and writes are ignored.
  - Release is synchronous to nothing. The first possible write is the first rising CLK edge with RESET high.
- Write:
  - On rising CLK, if RESET=1, WRITE=1 and BUSYWAIT=0: regs[INADDRESS] <= IN and valid[INADDRESS] <= 1.
  - Any other combination leaves all state unchanged.
- Stall: BUSYWAIT=1 at the edge suppresses the write completely. The control unit holds WRITE/IN/INADDRESS, and the write lands on the first edge with BUSYWAIT=0.
- Read:
  - Purely combinational: OUT1 = regs[OUT1ADDRESS], OUT2 = regs[OUT2ADDRESS], OUTn_VALID = valid[OUTnADDRESS].
  - Both ports may address the same register and return identical values.
- Read latency: 0 cycles. Write latency: new value visible on reads immediately after the write edge.
- Read-during-write, same address:
  - BYPASS=0: the read returns the old value until the edge, then the new one.
  - BYPASS=1: when WRITE=1, BUSYWAIT=0, RESET=1 and OUTnADDRESS==INADDRESS, OUTn = IN and OUTn_VALID = 1 combinationally, before the edge.
- Widths:
  - IN is stored unmodified; there is no sign handling here, since two's-complement negation is the ALU mux's job.
  - Addresses use all ADDR_W bits; there are no out-of-range cases.
- Reset mid-write: if RESET falls in the same cycle as a pending write, reset wins; the register reads 0 and valid = 0.
- Back-to-back writes to the same register on consecutive edges: last write wins, one value per edge.
- No X on outputs after the first reset. Before the first reset, outputs are undefined and are not checked.

Test Plan:
- Reset: pulse RESET low at t=2 with no CLK edge -> OUT1=OUT2=0 and OUT1_VALID=OUT2_VALID=0 immediately, for every address 0..7.
- Write/read: write 25->r1 and 34->r2 on consecutive edges; then set OUT1ADDRESS=1, OUT2ADDRESS=2 -> OUT1=25, OUT2=34, both VALID=1; r3 reads 0 with VALID=0.
- Stall: WRITE=1, IN=0xFF, INADDRESS=4, BUSYWAIT=1 for 3 edges -> r4 stays 0, VALID=0. BUSYWAIT drops -> r4=0xFF after the next edge.
- Same-address read/write: r5=7, then IN=9 to r5 with OUT2ADDRESS=5 -> before the edge, OUT2=7 (BYPASS=0) or 9 (BYPASS=1); after the edge, 9 in both builds.
- Reset mid-operation: write 0xAA->r6, then drop RESET between edges while WRITE=1, IN=0x55, INADDRESS=6 -> r6 reads 0 at once, stays 0 through the edge, VALID=0.
- Boundary values: write 0, 1, 0x80 and 0xFF to r7 on successive edges, reading both ports at r7 -> each value returned unmodified on OUT1 and OUT2.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: 8 x 8-bit general-purpose register file feeding the ALU.
//   CLK          rising-edge clock
//   RESET        asynchronous active-low reset; clears data and written flags
//   IN           write-back data, stored unmodified
//   INADDRESS    destination register
//   WRITE        write enable from the control unit
//   BUSYWAIT     memory stall; a write is held off while high
//   OUT1ADDRESS  read port 1 address
//   OUT2ADDRESS  read port 2 address
//   OUT1/OUT2    combinational read data (ALU DATA1 / toward DATA2)
//   OUTn_VALID   addressed register has been written since the last reset
// BYPASS=1 forwards IN to a read port that addresses the register being
// written in the same cycle.
module reg_file #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter bit          BYPASS = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic              BUSYWAIT,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              OUT1_VALID,
  output logic              OUT2_VALID
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic              wr_en;

  // A write commits only outside reset and when memory is not stalling.
  assign wr_en = RESET & WRITE & ~BUSYWAIT;

  // Storage and written-since-reset flags.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
      valid <= '0;
    end else if (wr_en) begin
      regs[INADDRESS]  <= IN;
      valid[INADDRESS] <= 1'b1;
    end
  end

  // Read ports, with optional same-cycle write-through.
  always_comb begin
    OUT1       = regs[OUT1ADDRESS];
    OUT1_VALID = valid[OUT1ADDRESS];
    OUT2       = regs[OUT2ADDRESS];
    OUT2_VALID = valid[OUT2ADDRESS];
    if (BYPASS && wr_en && (OUT1ADDRESS == INADDRESS)) begin
      OUT1       = IN;
      OUT1_VALID = 1'b1;
    end
    if (BYPASS && wr_en && (OUT2ADDRESS == INADDRESS)) begin
      OUT2       = IN;
      OUT2_VALID = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file. Two instances share all
// inputs: one write-back-only (BYPASS=0) and one write-through (BYPASS=1).
// A behavioural model predicts every read; predictions are queued when the
// stimulus is applied and popped when the outputs are sampled.
module tb_reg_file;

  logic       CLK;
  logic       RESET;
  logic [7:0] IN;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic       BUSYWAIT;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic [7:0] OUT1, OUT2, B_OUT1, B_OUT2;
  logic       OUT1_VALID, OUT2_VALID, B_OUT1_VALID, B_OUT2_VALID;
  logic       clk_en;

  reg_file #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b0)) dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS),
    .WRITE(WRITE), .BUSYWAIT(BUSYWAIT),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(OUT1), .OUT2(OUT2), .OUT1_VALID(OUT1_VALID), .OUT2_VALID(OUT2_VALID)
  );

  reg_file #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b1)) dut_byp (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS),
    .WRITE(WRITE), .BUSYWAIT(BUSYWAIT),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(B_OUT1), .OUT2(B_OUT2), .OUT1_VALID(B_OUT1_VALID), .OUT2_VALID(B_OUT2_VALID)
  );

  // Clock toggles only once enabled so the reset check sees no edge.
  always begin
    #5;
    if (clk_en) CLK = ~CLK;
  end

  typedef struct packed {
    logic [7:0] o1, o2;
    logic       v1, v2;
    logic [7:0] bo1, bo2;
    logic       bv1, bv2;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];

  logic [7:0] m_regs [8];
  logic [7:0] m_valid;
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_valid = 8'h00;
  endtask

  // Predict both instances' read ports from the model and current inputs.
  task automatic push(input string tag);
    exp_t e;
    logic byp;
    e.o1 = m_regs[OUT1ADDRESS];
    e.v1 = m_valid[OUT1ADDRESS];
    e.o2 = m_regs[OUT2ADDRESS];
    e.v2 = m_valid[OUT2ADDRESS];
    byp  = RESET && WRITE && !BUSYWAIT;
    e.bo1 = (byp && OUT1ADDRESS == INADDRESS) ? IN : e.o1;
    e.bv1 = (byp && OUT1ADDRESS == INADDRESS) ? 1'b1 : e.v1;
    e.bo2 = (byp && OUT2ADDRESS == INADDRESS) ? IN : e.o2;
    e.bv2 = (byp && OUT2ADDRESS == INADDRESS) ? 1'b1 : e.v2;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic sample();
    exp_t  e;
    string t;
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 8'd1, 8'd0);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".out1"},   OUT1,               e.o1);
    check({t, ".out2"},   OUT2,               e.o2);
    check({t, ".v1"},     8'(OUT1_VALID),     8'(e.v1));
    check({t, ".v2"},     8'(OUT2_VALID),     8'(e.v2));
    check({t, ".b_out1"}, B_OUT1,             e.bo1);
    check({t, ".b_out2"}, B_OUT2,             e.bo2);
    check({t, ".b_v1"},   8'(B_OUT1_VALID),   8'(e.bv1));
    check({t, ".b_v2"},   8'(B_OUT2_VALID),   8'(e.bv2));
  endtask

  task automatic expect_now(input string tag);
    push(tag);
    sample();
  endtask

  // One rising edge: the model commits what the DUT should, then return mid-low phase.
  task automatic tick();
    @(posedge CLK);
    if (RESET && WRITE && !BUSYWAIT) begin
      m_regs[INADDRESS]  = IN;
      m_valid[INADDRESS] = 1'b1;
    end
    @(negedge CLK);
  endtask

  task automatic drive(input logic we, input logic bw, input logic [7:0] din,
                       input logic [2:0] wa, input logic [2:0] a1, input logic [2:0] a2);
    WRITE = we; BUSYWAIT = bw; IN = din; INADDRESS = wa;
    OUT1ADDRESS = a1; OUT2ADDRESS = a2;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bvals [4];
    bvals[0] = 8'h00; bvals[1] = 8'h01; bvals[2] = 8'h80; bvals[3] = 8'hFF;
    CLK = 1'b0; clk_en = 1'b0; RESET = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 3'd0);
    model_reset();

    // Asynchronous reset with no clock edge, all addresses.
    #2 RESET = 1'b0;
    model_reset();
    for (int a = 0; a < 8; a++) begin
      OUT1ADDRESS = 3'(a);
      OUT2ADDRESS = 3'(7 - a);
      expect_now("reset");
    end
    RESET = 1'b1;
    clk_en = 1'b1;
    @(negedge CLK);

    // Write 25->r1, 34->r2 on consecutive edges, then read.
    drive(1'b1, 1'b0, 8'd25, 3'd1, 3'd3, 3'd3);
    tick();
    drive(1'b1, 1'b0, 8'd34, 3'd2, 3'd3, 3'd3);
    tick();
    drive(1'b0, 1'b0, 8'd0, 3'd0, 3'd1, 3'd2);
    expect_now("wr_rd");
    drive(1'b0, 1'b0, 8'd0, 3'd0, 3'd3, 3'd3);
    expect_now("unwritten_r3");

    // Stall: write to r4 held off for three edges, lands after release.
    drive(1'b1, 1'b1, 8'hFF, 3'd4, 3'd4, 3'd4);
    for (int i = 0; i < 3; i++) begin
      expect_now("stall_pre");
      tick();
    end
    expect_now("stall_held");
    BUSYWAIT = 1'b0;
    expect_now("stall_release_pre");
    tick();
    WRITE = 1'b0;
    expect_now("stall_landed");

    // Same-address read during write on r5.
    drive(1'b1, 1'b0, 8'd7, 3'd5, 3'd1, 3'd0);
    tick();
    drive(1'b1, 1'b0, 8'd9, 3'd5, 3'd1, 3'd5);
    expect_now("rdw_pre");
    tick();
    WRITE = 1'b0;
    expect_now("rdw_post");

    // Reset falls between edges with a write pending to r6.
    drive(1'b1, 1'b0, 8'hAA, 3'd6, 3'd6, 3'd6);
    tick();
    WRITE = 1'b0;
    expect_now("r6_written");
    drive(1'b1, 1'b0, 8'h55, 3'd6, 3'd6, 3'd1);
    #1 RESET = 1'b0;
    model_reset();
    expect_now("midrst_now");
    tick();
    expect_now("midrst_edge");
    WRITE = 1'b0;
    RESET = 1'b1;
    expect_now("midrst_release");

    // Boundary values to r7, back-to-back edges, both ports on r7.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, bvals[i], 3'd7, 3'd7, 3'd7);
      expect_now("bound_pre");
      tick();
      if (i == 3) WRITE = 1'b0;
      expect_now("bound_post");
    end

    // Randomised writes/stalls/reads against the model.
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            8'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      expect_now("rand_pre");
      tick();
    end
    WRITE = 1'b0;
    expect_now("rand_final");

    if (exp_q.size() != 0) check("scoreboard_left", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
